// File: rtl/keyboard_pkg.sv
// Shared scan-code-set-2 constants and decoder state type for the keyboard tracker.
// Pure declarations: no latency, no flow control.
package keyboard_pkg;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_PAUSE   = 8'hE1;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } kbd_state_t;

  // Status/handshake bytes that the decoder drops while in IDLE.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: byte_valid/err 1 cycle after the stop-bit strobe, strobe 2+FILTER_LEN
// cycles after the pin edge; no backpressure, bytes are at least ~11 bit periods apart.
module ps2_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic [TW-1:0] to_cnt;
  logic          fall;

  // The filtered clock is about to flip from 1 to 0 this cycle.
  assign fall = clk_filt && !clk_sync[1] && (filt_cnt == FILT_LAST);

  always_ff @(posedge pclk) begin
    if (rst) begin
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      clk_filt   <= 1'b1;
      filt_cnt   <= '0;
      bit_cnt    <= 4'd0;
      shreg      <= 9'd0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      err        <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      dat_sync   <= {dat_sync[0], ps2_data};
      byte_valid <= 1'b0;
      err        <= 1'b0;

      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end

      if (fall) begin
        to_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          if (!dat_sync[1]) bit_cnt <= 4'd1;
          else              err     <= 1'b1;
        end else if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          // shreg holds 8 data bits plus parity; odd parity means XOR of all nine is 1.
          if (dat_sync[1] && (^shreg)) begin
            byte_valid <= 1'b1;
            byte_data  <= shreg[7:0];
          end else begin
            err <= 1'b1;
          end
        end else begin
          shreg   <= {dat_sync[1], shreg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt == 4'd0) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_LAST) begin
        err     <= 1'b1;
        bit_cnt <= 4'd0;
        to_cnt  <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keyboard_tracker.sv
// PS/2 keyboard to key-state map: key_valid/last_change/key_down update 1 cycle after the final
// byte; no backpressure, the consumer must take every one-cycle key_valid/frame_err pulse.
module keyboard_tracker
  import keyboard_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [511:0] key_down,
  output logic [8:0]   last_change,
  output logic         key_valid,
  output logic         frame_err
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       rx_err;
  kbd_state_t state;
  logic [2:0] skip_cnt;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .pclk       (pclk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .err        (rx_err)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= ST_IDLE;
      skip_cnt    <= 3'd0;
      key_down    <= '0;
      last_change <= 9'h000;
      key_valid   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= rx_err;
      // The receiver never raises err and byte_valid together, so the pulses stay exclusive.
      if (rx_err) begin
        state <= ST_IDLE;
      end else if (byte_valid) begin
        case (state)
          ST_IDLE: begin
            if (byte_data == SC_EXT) begin
              state <= ST_EXT;
            end else if (byte_data == SC_BRK) begin
              state <= ST_BRK;
            end else if (byte_data == SC_PAUSE) begin
              state    <= ST_PAUSE;
              skip_cnt <= PAUSE_SKIP;
            end else if (!is_ignored(byte_data)) begin
              key_down[{1'b0, byte_data}] <= 1'b1;
              last_change                 <= {1'b0, byte_data};
              key_valid                   <= 1'b1;
            end
          end
          ST_EXT: begin
            if (byte_data == SC_BRK) begin
              state <= ST_EXT_BRK;
            end else begin
              key_down[{1'b1, byte_data}] <= 1'b1;
              last_change                 <= {1'b1, byte_data};
              key_valid                   <= 1'b1;
              state                       <= ST_IDLE;
            end
          end
          ST_BRK: begin
            key_down[{1'b0, byte_data}] <= 1'b0;
            last_change                 <= {1'b0, byte_data};
            key_valid                   <= 1'b1;
            state                       <= ST_IDLE;
          end
          ST_EXT_BRK: begin
            key_down[{1'b1, byte_data}] <= 1'b0;
            last_change                 <= {1'b1, byte_data};
            key_valid                   <= 1'b1;
            state                       <= ST_IDLE;
          end
          ST_PAUSE: begin
            skip_cnt <= skip_cnt - 3'd1;
            if (skip_cnt == 3'd1) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keyboard_tracker.sv
// Scoreboard bench for keyboard_tracker: a sequence-level model predicts every event/error,
// a negedge monitor pops and compares whenever key_valid or frame_err is seen.
module tb_keyboard_tracker;

  localparam int FL   = 4;
  localparam int TO   = 600;
  localparam int HALF = 16;

  logic         pclk = 1'b0;
  logic         rst = 1'b1;
  logic         ps2_clk = 1'b1;
  logic         ps2_data = 1'b1;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic         frame_err;

  always #5 pclk = ~pclk;

  keyboard_tracker #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_down    (key_down),
    .last_change (last_change),
    .key_valid   (key_valid),
    .frame_err   (frame_err)
  );

  typedef struct {
    bit           is_err;
    logic [8:0]   code;
    logic [511:0] map;
  } exp_t;

  exp_t         expq[$];
  logic [7:0]   pend[$];
  logic [511:0] model_keys = '0;
  int           checks = 0;
  int           errors = 0;

  task automatic check_val(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: interprets the byte stream as whole scan-code sequences.
  function automatic void push_event(input bit brk, input bit ext, input logic [7:0] code);
    exp_t e;
    model_keys[{ext, code}] = !brk;
    e.is_err = 1'b0;
    e.code   = {ext, code};
    e.map    = model_keys;
    expq.push_back(e);
  endfunction

  function automatic void model_err();
    exp_t e;
    pend.delete();
    e.is_err = 1'b1;
    e.code   = 9'h000;
    e.map    = '0;
    expq.push_back(e);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    pend.push_back(b);
    if (pend[0] == 8'hE1) begin
      if (pend.size() == 8) pend.delete();
    end else if (pend.size() == 1) begin
      if (b != 8'hE0 && b != 8'hF0) begin
        if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) push_event(1'b0, 1'b0, b);
        pend.delete();
      end
    end else if (pend[0] == 8'hE0) begin
      if (!(pend.size() == 2 && b == 8'hF0)) begin
        push_event(pend.size() == 3, 1'b1, b);
        pend.delete();
      end
    end else begin
      push_event(1'b1, 1'b0, b);
      pend.delete();
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    cyc(HALF / 2);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
    cyc(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_par || bad_stop) model_err();
    else                     model_byte(b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(!bad_stop);
    ps2_data = 1'b1;
    cyc(40);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits - 1; i++) ps2_bit(b[i]);
    ps2_data = 1'b1;
  endtask

  task automatic check_reset_state();
    check_val("rst_key_down", key_down, '0);
    check_val("rst_last_change", {503'd0, last_change}, 512'd0);
    check_val("rst_key_valid", {511'd0, key_valid}, 512'd0);
    check_val("rst_frame_err", {511'd0, frame_err}, 512'd0);
  endtask

  always @(negedge pclk) begin : monitor
    exp_t e;
    if (!rst && (key_valid || frame_err)) begin
      if (key_valid && frame_err) begin
        checks++;
        errors++;
        $display("FAIL exclusive key_valid=1 frame_err=1 required one of them 0");
      end else if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse key_valid=%0b frame_err=%0b last_change=%0h required no pulse",
                 key_valid, frame_err, last_change);
      end else begin
        e = expq.pop_front();
        check_val("pulse_kind_err", {511'd0, frame_err}, {511'd0, e.is_err});
        if (!e.is_err) begin
          check_val("last_change", {503'd0, last_change}, {503'd0, e.code});
          check_val("key_down", key_down, e.map);
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    rst = 1'b1;
    cyc(5);
    check_reset_state();
    rst = 1'b0;
    cyc(10);

    // Partial frame killed by reset: no frame_err, next frame starts clean.
    send_partial(8'h29, 4);
    rst = 1'b1;
    cyc(3);
    model_keys = '0;
    pend.delete();
    check_reset_state();
    rst = 1'b0;
    cyc(10);

    send(8'h29);
    send(8'hF0); send(8'h29);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);

    send_frame(8'h29, 1'b1, 1'b0);
    send(8'h29);

    send_partial(8'h1C, 5);
    model_err();
    cyc(TO + 20);
    send(8'h1C);

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'hF0); send(8'h29);

    send(8'hAA);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'hFA);
    send(8'h29);

    send(8'hE0);
    send_frame(8'h33, 1'b0, 1'b1);
    send(8'h33);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFA;
        5:       b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'($urandom_range(1, 8'h83));
        default: b = 8'($urandom_range(1, 8'h83));
      endcase
      send_frame(b, $urandom_range(0, 15) == 0, 1'b0);
    end

    for (int i = 0; i < 3000 && expq.size() != 0; i++) @(negedge pclk);
    check_val("queue_drained", 512'(expq.size()), 512'd0);
    check_val("final_key_down", key_down, model_keys);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keyboard_tracker.md
# keyboard_tracker

Converts the raw PS/2 keyboard line into the key-state view the game logic consumes: a 512-bit pressed-key map, the 9-bit code of the most recent make/break, and a one-cycle valid strobe. Sits directly upstream of the game-logic block and drives its `key_down`, `last_change` and `key_valid` inputs. Contains the PS/2 serial receiver and the scan-code-set-2 prefix decoder.

## Interface
- `FILTER_LEN`, default 4: number of consecutive equal samples required before the synchronized `ps2_clk` level is accepted.
- `TIMEOUT_CYCLES`, default 50000: idle `pclk` cycles mid-frame before the frame is aborted (2 ms at 25 MHz).
- `pclk`  in  1  system/pixel clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `key_down`  out  512  bit `{ext,code}` is 1 while that key is held.
- `last_change`  out  9  `{ext,code}` of the last completed make or break.
- `key_valid`  out  1  one-cycle pulse per completed make or break.
- `frame_err`  out  1  one-cycle pulse on a framing, parity or timeout error.

## Operation
- Receiver (`ps2_rx`):
  - 2-FF synchronizers on both lines, then the `FILTER_LEN` glitch filter on the clock.
  - Data is sampled on the filtered clock's falling edge.
  - Frame format: start=0, 8 data bits LSB first, odd parity, stop=1.
  - On a good frame, pulses `byte_valid` with `byte_data`.
  - On a bad start bit, parity or stop bit, the byte is dropped and `frame_err` pulses.
  - Timeout: if the bit count is nonzero and no falling edge arrives for `TIMEOUT_CYCLES`, the frame is aborted and `frame_err` pulses.
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
  - IDLE:
    - E0 goes to EXT.
    - F0 goes to BRK.
    - E1 goes to PAUSE and loads the skip counter with 7.
    - AA, FA, EE, FE, 00 and FF are discarded (stay in IDLE).
    - Any other byte is a make with ext=0.
  - EXT: F0 goes to EXT_BRK; any other byte is a make with ext=1.
  - BRK: any byte is a break with ext=0.
  - EXT_BRK: any byte is a break with ext=1.
  - PAUSE: discards bytes until the counter reaches 0, then returns to IDLE. No event is produced.
  - After every make or break, the FSM returns to IDLE.
- Make: sets `key_down[{ext,code}]`, loads `last_change`, pulses `key_valid`.
  - Typematic repeats pulse `key_valid` again; `key_down` stays 1.
- Break: clears the bit, loads `last_change`, pulses `key_valid`.
  - A break for a key not held still pulses `key_valid`.
- Any `frame_err` forces the FSM to IDLE, discarding a pending prefix. `key_down` is untouched.

## Timing
- Reset values: `key_down`=0, `last_change`=9'h000, `key_valid`=0, `frame_err`=0; FSM in IDLE, receiver bit count 0.
- `rst` mid-frame aborts the partial byte with no `frame_err`; the next falling edge is treated as a start bit.
- Input latency: sync 2 cycles plus `FILTER_LEN` cycles from the `ps2_clk` pin edge to the internal falling-edge strobe.
- `byte_valid` asserts 1 cycle after the stop-bit falling-edge strobe.
- `key_valid`, `last_change` and `key_down` update together, 1 cycle after the final byte's `byte_valid`.
  - So the consumer sees `key_down[last_change]` already updated when `key_valid` is high.
- `key_valid` and `frame_err` are never high together. Both are exactly 1 cycle wide.
- Back-to-back bytes can never arrive closer than about 11 PS/2 bit periods, so no input buffering is required.
- The timeout counter resets on every falling edge and holds at 0 while idle (bit count 0).

## Structure
- Package `keyboard_pkg`:
  - Constants `SC_EXT`=8'hE0, `SC_BRK`=8'hF0, `SC_PAUSE`=8'hE1.
  - The ignore list.
  - `PAUSE_SKIP`=7.
  - The FSM state enum.
- Sub-module `ps2_rx`: synchronizers, filter, bit shifter, parity check and timeout. Ports `pclk`, `rst`, `ps2_clk`, `ps2_data`, `byte_valid`, `byte_data[7:0]`, `err`.
- Top level: decoder FSM and the 512-bit key map.

## Test plan
- Frame 29 → `key_valid` pulse, `last_change`=9'h029, `key_down[41]`=1, all other bits 0.
- Frames F0, 29 after the above → `key_valid` pulses once (after 29 only), `last_change`=9'h029, `key_down[41]`=0.
- Frames E0 75, then E0 F0 75 → first `last_change`=9'h175 with `key_down[373]`=1; then `key_down[373]`=0. Exactly 2 `key_valid` pulses total.
- Frame 29 with a wrong parity bit → one `frame_err` pulse, no `key_valid`, `key_down` unchanged. A following clean 29 is decoded normally.
- Frame stalled after 5 bits for `TIMEOUT_CYCLES`+1 cycles → `frame_err` pulse. The next full frame 1C gives `last_change`=9'h01C.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 29 → no events for the 8 Pause bytes; a single event for 9'h029. Repeat with AA/FA injected in IDLE → no events for the injected bytes.
